// File: rtl/rob_alloc_seq_pkg.sv
// Shared ROB geometry, the phase+index id type and phase-aware id arithmetic
// used by the sequential ROB allocator slice.
package nvio_rob_pkg;

  localparam int QENTRIES = 8;
  localparam int RENTRIES = 16;
  localparam int QB       = $clog2(QENTRIES);
  localparam int RIB      = $clog2(RENTRIES);
  localparam int RB       = RIB + 1;
  localparam int FW       = $clog2(RENTRIES + 1);

  localparam logic [2:0] IQS_QUEUED = 3'd1;

  typedef struct packed {
    logic           phase;
    logic [RIB-1:0] idx;
  } rob_id_t;

  // With a power-of-two ROB the phase bit sits directly above the index, so a
  // plain RB-bit add wraps the index and toggles the phase in one step.
  function automatic rob_id_t rob_id_add(input rob_id_t base, input logic [RB-1:0] inc);
    logic [RB-1:0] sum_s;
    sum_s = base + inc;
    return rob_id_t'(sum_s);
  endfunction

endpackage

// File: rtl/rob_alloc_seq_if.sv
// Queue/commit-side bundle of the ROB allocator. The stall_cycles signal only
// exists when ROB_ALLOC_STATS_EN is defined.
interface rob_alloc_seq_if
  import nvio_rob_pkg::*;
#(
  parameter int RSLOTS = 3,
  parameter int CSLOTS = 2
) ();

  logic [QENTRIES-1:0][QB-1:0]           heads;
  logic [QENTRIES-1:0][2:0]              iq_state;
  logic                                  alloc_stall;
  logic [$clog2(CSLOTS+1)-1:0]           cmt_cnt;
  logic                                  flush;
  logic [RB-1:0]                         flush_rid;
  logic [$clog2(RSLOTS+1)-1:0]           grant_cnt;
  logic [QENTRIES-1:0]                   grant_on;
  logic [QENTRIES-1:0][RB-1:0]           grant_rid;
  logic [RENTRIES-1:0]                   rob_v;
  logic [RB-1:0]                         rob_tail;
  logic [RB-1:0]                         rob_head;
  logic [FW-1:0]                         rob_free;
`ifdef ROB_ALLOC_STATS_EN
  logic [31:0]                           stall_cycles;
`endif

  modport master (
    output heads, iq_state, alloc_stall, cmt_cnt, flush, flush_rid,
    input  grant_cnt, grant_on, grant_rid, rob_v, rob_tail, rob_head, rob_free
`ifdef ROB_ALLOC_STATS_EN
    , input stall_cycles
`endif
  );

  modport slave (
    input  heads, iq_state, alloc_stall, cmt_cnt, flush, flush_rid,
    output grant_cnt, grant_on, grant_rid, rob_v, rob_tail, rob_head, rob_free
`ifdef ROB_ALLOC_STATS_EN
    , output stall_cycles
`endif
  );

endinterface

// File: rtl/rob_alloc_seq_chk.sv
// Protocol checker for the ROB allocator: a commit may never retire more
// entries than the ROB currently holds.
module rob_alloc_seq_chk
  import nvio_rob_pkg::*;
#(
  parameter int CSLOTS = 2
) (
  input logic                        clk,
  input logic                        rst,
  input logic [$clog2(CSLOTS+1)-1:0] cmt_cnt,
  input logic [FW-1:0]               rob_free
);

  // Occupancy is RENTRIES - rob_free; compare on every active cycle.
  always @(posedge clk) begin
    if (!rst) begin
      assert (FW'(cmt_cnt) <= (FW'(RENTRIES) - rob_free));
    end
  end

endmodule

// File: rtl/rob_alloc_seq_grant_sel.sv
// Age-ordered grant selector: walks the queue oldest first and hands out up to
// `limit` grants, each tagged with its offset from the current ROB tail.
module rob_grant_sel
  import nvio_rob_pkg::*;
#(
  parameter int RSLOTS  = 3,
  parameter int INORDER = 0,
  localparam int CW     = $clog2(RSLOTS + 1)
) (
  input  logic [QENTRIES-1:0][QB-1:0] heads,
  input  logic [QENTRIES-1:0][2:0]    iq_state,
  input  logic [CW-1:0]               limit,
  output logic [QENTRIES-1:0]         grant_on,
  output logic [QENTRIES-1:0][CW-1:0] grant_off,
  output logic [CW-1:0]               grant_cnt
);

  logic [CW-1:0] k_s;
  logic          stop_s;

  // In-order mode freezes the walk at the first entry that cannot be granted.
  always_comb begin
    grant_on  = {QENTRIES{1'b0}};
    grant_off = {(QENTRIES*CW){1'b0}};
    k_s       = {CW{1'b0}};
    stop_s    = 1'b0;
    for (int n = 0; n < QENTRIES; n++) begin
      if (!stop_s && (iq_state[heads[n]] == IQS_QUEUED) && (k_s < limit)) begin
        grant_on[heads[n]]  = 1'b1;
        grant_off[heads[n]] = k_s;
        k_s                 = k_s + CW'(1);
      end else if (INORDER != 0) begin
        stop_s = 1'b1;
      end else begin
        stop_s = stop_s;
      end
    end
    grant_cnt = k_s;
  end

endmodule

// File: rtl/rob_alloc_seq.sv
// Sequential ROB allocator: owns head/tail pointers, the valid vector and the
// free count. Optional stall statistics counter under ROB_ALLOC_STATS_EN.
module rob_alloc_seq
  import nvio_rob_pkg::*;
#(
  parameter int RSLOTS  = 3,
  parameter int CSLOTS  = 2,
  parameter int INORDER = 0
) (
  input logic            clk,
  input logic            rst,
  rob_alloc_seq_if.slave bus
);

  localparam int CW = $clog2(RSLOTS + 1);

  rob_id_t                     tail_r, head_r, tail_nxt_s, head_nxt_s, frid_s, slot_s;
  logic [RENTRIES-1:0]         v_r, v_nxt_s;
  logic [FW-1:0]               free_r, free_nxt_s;
  logic [RB-1:0]               flush_span_s;
  logic [CW-1:0]               limit_s, sel_cnt_s;
  logic [QENTRIES-1:0]         sel_on_s;
  logic [QENTRIES-1:0][CW-1:0] sel_off_s;

  assign frid_s = rob_id_t'(bus.flush_rid);

  // Grant budget: zero under reset, stall or flush, else min(RSLOTS, free).
  always_comb begin
    if (rst || bus.alloc_stall || bus.flush) begin
      limit_s = {CW{1'b0}};
    end else if (free_r < FW'(RSLOTS)) begin
      limit_s = CW'(free_r);
    end else begin
      limit_s = CW'(RSLOTS);
    end
  end

  rob_grant_sel #(
    .RSLOTS  (RSLOTS),
    .INORDER (INORDER)
  ) u_sel (
    .heads     (bus.heads),
    .iq_state  (bus.iq_state),
    .limit     (limit_s),
    .grant_on  (sel_on_s),
    .grant_off (sel_off_s),
    .grant_cnt (sel_cnt_s)
  );

  // Grant outputs; ids are only meaningful where grant_on is set.
  always_comb begin
    bus.grant_cnt = sel_cnt_s;
    bus.grant_on  = sel_on_s;
    for (int q = 0; q < QENTRIES; q++) begin
      if (sel_on_s[q]) begin
        bus.grant_rid[q] = rob_id_add(tail_r, RB'(sel_off_s[q]));
      end else begin
        bus.grant_rid[q] = {RB{1'b0}};
      end
    end
  end

  // Next pointer/valid/free state. Flush clears [flush_rid, old tail) and
  // rebuilds the free count from the post-commit head.
  always_comb begin
    head_nxt_s   = rob_id_add(head_r, RB'(bus.cmt_cnt));
    flush_span_s = RB'(tail_r) - RB'(frid_s);
    v_nxt_s      = v_r;
    slot_s       = tail_r;
    for (int i = 0; i < RSLOTS; i++) begin
      slot_s = rob_id_add(tail_r, RB'(i));
      if (CW'(i) < sel_cnt_s) begin
        v_nxt_s[slot_s.idx] = 1'b1;
      end else begin
        v_nxt_s[slot_s.idx] = v_nxt_s[slot_s.idx];
      end
    end
    for (int i = 0; i < CSLOTS; i++) begin
      slot_s = rob_id_add(head_r, RB'(i));
      if (bus.cmt_cnt > $bits(bus.cmt_cnt)'(i)) begin
        v_nxt_s[slot_s.idx] = 1'b0;
      end else begin
        v_nxt_s[slot_s.idx] = v_nxt_s[slot_s.idx];
      end
    end
    for (int j = 0; j < RENTRIES; j++) begin
      slot_s = rob_id_add(frid_s, RB'(j));
      if (bus.flush && (RB'(j) < flush_span_s)) begin
        v_nxt_s[slot_s.idx] = 1'b0;
      end else begin
        v_nxt_s[slot_s.idx] = v_nxt_s[slot_s.idx];
      end
    end
    if (bus.flush) begin
      tail_nxt_s = frid_s;
      free_nxt_s = FW'(RENTRIES) - FW'(RB'(frid_s) - RB'(head_nxt_s));
    end else begin
      tail_nxt_s = rob_id_add(tail_r, RB'(sel_cnt_s));
      free_nxt_s = free_r + FW'(bus.cmt_cnt) - FW'(sel_cnt_s);
    end
  end

  // State registers; reset discards any grant computed in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tail_r <= rob_id_t'({RB{1'b0}});
      head_r <= rob_id_t'({RB{1'b0}});
      v_r    <= {RENTRIES{1'b0}};
      free_r <= FW'(RENTRIES);
    end else begin
      tail_r <= tail_nxt_s;
      head_r <= head_nxt_s;
      v_r    <= v_nxt_s;
      free_r <= free_nxt_s;
    end
  end

  assign bus.rob_v    = v_r;
  assign bus.rob_tail = tail_r;
  assign bus.rob_head = head_r;
  assign bus.rob_free = free_r;

`ifdef ROB_ALLOC_STATS_EN
  logic [31:0] stall_r;
  logic        any_q_s;

  // Any QUEUED entry anywhere in the instruction queue.
  always_comb begin
    any_q_s = 1'b0;
    for (int q = 0; q < QENTRIES; q++) begin
      if (bus.iq_state[q] == IQS_QUEUED) begin
        any_q_s = 1'b1;
      end else begin
        any_q_s = any_q_s;
      end
    end
  end

  // Saturating count of cycles starved purely by a full ROB.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r <= 32'd0;
    end else if (any_q_s && (free_r == {FW{1'b0}}) && (stall_r != 32'hFFFF_FFFF)) begin
      stall_r <= stall_r + 32'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign bus.stall_cycles = stall_r;
`endif

endmodule

// File: tb/tb_rob_alloc_seq.sv
// Self-checking bench for rob_alloc_seq: reset, in-order vs skip mode, a
// vector table through wrap/full/flush, and mid-run reset.
module tb_rob_alloc_seq;
  import nvio_rob_pkg::*;

  localparam int RSLOTS = 3;
  localparam int CSLOTS = 2;
  localparam int NV     = 23;

  typedef struct {
    logic [7:0]  qmask;
    logic        rev;
    logic        stall;
    logic [1:0]  cmt;
    logic        flush;
    logic [4:0]  frid;
    logic [1:0]  gcnt;
    logic [7:0]  gon;
    logic [4:0]  rid0;
    logic [4:0]  tail;
    logic [4:0]  head;
    logic [4:0]  free;
    logic [15:0] v;
  } vec_t;

  typedef struct {
    int          idx;
    logic [4:0]  tail;
    logic [4:0]  head;
    logic [4:0]  free;
    logic [15:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vt[NV];
  exp_t sb[$];

  always #5 clk = ~clk;

  rob_alloc_seq_if #(.RSLOTS(RSLOTS), .CSLOTS(CSLOTS)) bus_a ();
  rob_alloc_seq_if #(.RSLOTS(RSLOTS), .CSLOTS(CSLOTS)) bus_b ();

  rob_alloc_seq #(.RSLOTS(RSLOTS), .CSLOTS(CSLOTS), .INORDER(0)) dut (
    .clk (clk), .rst (rst), .bus (bus_a.slave));
  rob_alloc_seq #(.RSLOTS(RSLOTS), .CSLOTS(CSLOTS), .INORDER(1)) dut_io (
    .clk (clk), .rst (rst), .bus (bus_b.slave));
  rob_alloc_seq_chk #(.CSLOTS(CSLOTS)) chk (
    .clk (clk), .rst (rst), .cmt_cnt (bus_a.cmt_cnt), .rob_free (bus_a.rob_free));

  assign bus_b.heads       = bus_a.heads;
  assign bus_b.iq_state    = bus_a.iq_state;
  assign bus_b.alloc_stall = bus_a.alloc_stall;
  assign bus_b.cmt_cnt     = bus_a.cmt_cnt;
  assign bus_b.flush       = bus_a.flush;
  assign bus_b.flush_rid   = bus_a.flush_rid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] qmask, input logic rev, input logic stall,
                              input logic [1:0] cmt, input logic flush, input logic [4:0] frid,
                              input logic [1:0] gcnt, input logic [7:0] gon, input logic [4:0] rid0,
                              input logic [4:0] tail, input logic [4:0] head, input logic [4:0] free,
                              input logic [15:0] v);
    vec_t t;
    t = '{qmask, rev, stall, cmt, flush, frid, gcnt, gon, rid0, tail, head, free, v};
    return t;
  endfunction

  task automatic drive(input logic [7:0] qmask, input logic rev, input logic stall,
                       input logic [1:0] cmt, input logic flush, input logic [4:0] frid);
    for (int n = 0; n < QENTRIES; n++) begin
      bus_a.heads[n]    = rev ? QB'(QENTRIES - 1 - n) : QB'(n);
      bus_a.iq_state[n] = qmask[n] ? IQS_QUEUED : 3'd2;
    end
    bus_a.alloc_stall = stall;
    bus_a.cmt_cnt     = cmt;
    bus_a.flush       = flush;
    bus_a.flush_rid   = frid;
  endtask

  task automatic check_state(input string tag, input logic [4:0] tail, input logic [4:0] head,
                             input logic [4:0] free, input logic [15:0] v);
    check({tag, " rob_tail"}, 32'(bus_a.rob_tail), 32'(tail));
    check({tag, " rob_head"}, 32'(bus_a.rob_head), 32'(head));
    check({tag, " rob_free"}, 32'(bus_a.rob_free), 32'(free));
    check({tag, " rob_v"},    32'(bus_a.rob_v),    32'(v));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    exp_t e;
    int   k;
    int   ent;
    logic [4:0] rid;

    // qmask rev stall cmt flush frid | gcnt gon rid0 | tail head free v
    vt[0]  = mk(8'h07, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd3, 8'h07, 5'd0,  5'd3,  5'd0,  5'd13, 16'h0007);
    vt[1]  = mk(8'h00, 1'b0, 1'b0, 2'd2, 1'b0, 5'd0, 2'd0, 8'h00, 5'd0,  5'd3,  5'd2,  5'd15, 16'h0004);
    vt[2]  = mk(8'hFF, 1'b0, 1'b1, 2'd0, 1'b0, 5'd0, 2'd0, 8'h00, 5'd0,  5'd3,  5'd2,  5'd15, 16'h0004);
    vt[3]  = mk(8'hFF, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd3, 8'h07, 5'd3,  5'd6,  5'd2,  5'd12, 16'h003C);
    vt[4]  = mk(8'h0A, 1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 2'd2, 8'h0A, 5'd6,  5'd8,  5'd2,  5'd10, 16'h00FC);
    vt[5]  = mk(8'h03, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd2, 8'h03, 5'd8,  5'd10, 5'd2,  5'd8,  16'h03FC);
    vt[6]  = mk(8'hFF, 1'b0, 1'b0, 2'd1, 1'b1, 5'd5, 2'd0, 8'h00, 5'd0,  5'd5,  5'd3,  5'd14, 16'h0018);
    vt[7]  = mk(8'h00, 1'b0, 1'b0, 2'd2, 1'b0, 5'd0, 2'd0, 8'h00, 5'd0,  5'd5,  5'd5,  5'd16, 16'h0000);
    vt[8]  = mk(8'h07, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd3, 8'h07, 5'd5,  5'd8,  5'd5,  5'd13, 16'h00E0);
    vt[9]  = mk(8'h07, 1'b0, 1'b0, 2'd2, 1'b0, 5'd0, 2'd3, 8'h07, 5'd8,  5'd11, 5'd7,  5'd12, 16'h0780);
    vt[10] = mk(8'h07, 1'b0, 1'b0, 2'd2, 1'b0, 5'd0, 2'd3, 8'h07, 5'd11, 5'd14, 5'd9,  5'd11, 16'h3E00);
    vt[11] = mk(8'h07, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd3, 8'h07, 5'd14, 5'd17, 5'd9,  5'd8,  16'hFE01);
    vt[12] = mk(8'h07, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd3, 8'h07, 5'd17, 5'd20, 5'd9,  5'd5,  16'hFE0F);
    vt[13] = mk(8'h07, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd3, 8'h07, 5'd20, 5'd23, 5'd9,  5'd2,  16'hFE7F);
    vt[14] = mk(8'h01, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd1, 8'h01, 5'd23, 5'd24, 5'd9,  5'd1,  16'hFEFF);
    vt[15] = mk(8'h07, 1'b0, 1'b0, 2'd2, 1'b0, 5'd0, 2'd1, 8'h01, 5'd24, 5'd25, 5'd11, 5'd2,  16'hF9FF);
    vt[16] = mk(8'h07, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd2, 8'h03, 5'd25, 5'd27, 5'd11, 5'd0,  16'hFFFF);
    for (int i = 17; i < 22; i++) begin
      vt[i] = mk(8'h07, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0, 8'h00, 5'd0, 5'd27, 5'd11, 5'd0, 16'hFFFF);
    end
    vt[22] = mk(8'h00, 1'b0, 1'b0, 2'd2, 1'b0, 5'd0, 2'd0, 8'h00, 5'd0,  5'd27, 5'd13, 5'd2,  16'hE7FF);

    // Reset with QUEUED entries present: grant outputs held at zero.
    rst = 1'b1;
    drive(8'h07, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst grant_cnt", 32'(bus_a.grant_cnt), 32'd0);
    check("rst grant_on",  32'(bus_a.grant_on),  32'd0);
    @(posedge clk); #1;
    check_state("rst", 5'd0, 5'd0, 5'd16, 16'h0000);
    rst = 1'b0;

    // Age order [QUEUED, ISSUED, QUEUED]: skip mode vs in-order mode.
    drive(8'h05, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0);
    @(negedge clk);
    check("skip grant_cnt",     32'(bus_a.grant_cnt),    32'd2);
    check("skip grant_on",      32'(bus_a.grant_on),     32'h05);
    check("skip grant_rid[2]",  32'(bus_a.grant_rid[2]), 32'd1);
    check("inord grant_cnt",    32'(bus_b.grant_cnt),    32'd1);
    check("inord grant_on",     32'(bus_b.grant_on),     32'h01);
    rst = 1'b1;
    @(posedge clk); #1;
    check_state("rst-pending", 5'd0, 5'd0, 5'd16, 16'h0000);
    check("inord rob_v after rst", 32'(bus_b.rob_v), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      t = vt[i];
      drive(t.qmask, t.rev, t.stall, t.cmt, t.flush, t.frid);
      @(negedge clk);
      check($sformatf("v%0d grant_cnt", i), 32'(bus_a.grant_cnt), 32'(t.gcnt));
      check($sformatf("v%0d grant_on", i),  32'(bus_a.grant_on),  32'(t.gon));
      k = 0;
      for (int n = 0; n < QENTRIES; n++) begin
        ent = t.rev ? (QENTRIES - 1 - n) : n;
        if (t.gon[ent]) begin
          rid = t.rid0 + 5'(k);
          check($sformatf("v%0d grant_rid[%0d]", i, ent), 32'(bus_a.grant_rid[ent]), 32'(rid));
          k++;
        end
      end
      sb.push_back('{i, t.tail, t.head, t.free, t.v});
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        check("scoreboard underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_state($sformatf("v%0d", e.idx), e.tail, e.head, e.free, e.v);
      end
    end

`ifdef ROB_ALLOC_STATS_EN
    check("stall_cycles full", bus_a.stall_cycles, 32'd5);
`endif

    // Reset in the middle of a run with grants pending.
    drive(8'h07, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst grant_cnt", 32'(bus_a.grant_cnt), 32'd0);
    check("midrst grant_on",  32'(bus_a.grant_on),  32'd0);
    @(posedge clk); #1;
    check_state("midrst", 5'd0, 5'd0, 5'd16, 16'h0000);
`ifdef ROB_ALLOC_STATS_EN
    check("midrst stall_cycles", bus_a.stall_cycles, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("post-rst grant_cnt", 32'(bus_a.grant_cnt), 32'd3);
    check("post-rst grant_rid[0]", 32'(bus_a.grant_rid[0]), 32'd0);
    @(posedge clk); #1;
    check_state("post-rst", 5'd3, 5'd0, 5'd13, 16'h0007);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
